// File: rtl/board_io_bus_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : board_io_bus_slave_if
// Purpose  : Processor data-bus bundle for the board I/O register block.
// Revision : 1.0 - initial release
// ============================================================================
interface board_io_bus_slave_if;
    logic [31:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output addr, wr_en, rd_en, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  addr, wr_en, rd_en, wr_data,
        output rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/board_io_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : board_io_bus_slave
// Purpose  : Memory-mapped KEY/SW status and LEDR/HEX output registers.
// Revision : 1.0 - initial release
// ============================================================================
module board_io_bus_slave #(
    parameter logic [31:0] ADDR_KDATA      = 32'hF000_0000,
    parameter logic [31:0] ADDR_KCTRL      = 32'hF000_0004,
    parameter logic [31:0] ADDR_SDATA      = 32'hF000_0010,
    parameter logic [31:0] ADDR_SCTRL      = 32'hF000_0014,
    parameter logic [31:0] ADDR_LEDR       = 32'hF000_0020,
    parameter logic [31:0] ADDR_HEX        = 32'hF000_0030,
    parameter int unsigned DEBOUNCE_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    board_io_bus_slave_if.slave  bus,
    input  logic [3:0]           key_raw,
    input  logic [9:0]           sw_raw,
    output logic [9:0]           ledr_out,
    output logic [15:0]          hex_out
);

    localparam logic [15:0] c_CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  r_key_s1, r_key_s2, r_kdata, r_kdata_d;
    logic [9:0]  r_sw_s1, r_sw_s2, r_sw_prev, r_sdata, r_sdata_d;
    logic [15:0] r_sw_cnt;
    logic        r_krdy, r_kovr, r_srdy, r_sovr;
    logic [9:0]  r_ledr;
    logic [15:0] r_hex;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;

    logic [29:0] w_word;
    logic        w_sel_kdata, w_sel_kctrl, w_sel_sdata, w_sel_sctrl, w_sel_ledr, w_sel_hex;
    logic        w_k_set, w_s_set, w_k_clr, w_s_clr, w_k_ovr_clr, w_s_ovr_clr;
    logic        w_sw_stable;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    // Word decode: the byte-offset bits never take part in selection.
    assign w_word      = bus.addr[31:2];
    assign w_sel_kdata = (w_word == ADDR_KDATA[31:2]);
    assign w_sel_kctrl = (w_word == ADDR_KCTRL[31:2]);
    assign w_sel_sdata = (w_word == ADDR_SDATA[31:2]);
    assign w_sel_sctrl = (w_word == ADDR_SCTRL[31:2]);
    assign w_sel_ledr  = (w_word == ADDR_LEDR[31:2]);
    assign w_sel_hex   = (w_word == ADDR_HEX[31:2]);
    assign w_unused    = ^{bus.addr[1:0], bus.wr_data[31:16]};

    // A data register that moved on the previous edge raises ready on this one.
    assign w_k_set     = (r_kdata != r_kdata_d);
    assign w_s_set     = (r_sdata != r_sdata_d);
    assign w_k_clr     = bus.rd_en && w_sel_kdata;
    assign w_s_clr     = bus.rd_en && w_sel_sdata;
    assign w_k_ovr_clr = bus.wr_en && w_sel_kctrl && !bus.wr_data[2];
    assign w_s_ovr_clr = bus.wr_en && w_sel_sctrl && !bus.wr_data[2];
    assign w_sw_stable = (r_sw_s2 == r_sw_prev);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_key_s1  <= '0;
            r_key_s2  <= '0;
            r_kdata   <= '0;
            r_kdata_d <= '0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_sw_prev <= '0;
            r_sw_cnt  <= '0;
            r_sdata   <= '0;
            r_sdata_d <= '0;
        end else begin
            r_key_s1  <= ~key_raw;
            r_key_s2  <= r_key_s1;
            r_kdata   <= r_key_s2;
            r_kdata_d <= r_kdata;
            r_sw_s1   <= sw_raw;
            r_sw_s2   <= r_sw_s1;
            r_sw_prev <= r_sw_s2;
            r_sdata_d <= r_sdata;
            if (!w_sw_stable) begin
                r_sw_cnt <= '0;
            end else if (r_sw_cnt != c_CNT_MAX) begin
                r_sw_cnt <= r_sw_cnt + 16'd1;
            end
            if (w_sw_stable && (r_sw_cnt == c_CNT_MAX)) begin
                r_sdata <= r_sw_s2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_krdy <= 1'b0;
            r_kovr <= 1'b0;
            r_srdy <= 1'b0;
            r_sovr <= 1'b0;
        end else begin
            // Overrun is judged against the ready value before this edge.
            if (w_k_set && r_krdy && !w_k_clr) begin
                r_kovr <= 1'b1;
            end else if (w_k_ovr_clr) begin
                r_kovr <= 1'b0;
            end
            if (w_k_set) begin
                r_krdy <= 1'b1;
            end else if (w_k_clr) begin
                r_krdy <= 1'b0;
            end

            if (w_s_set && r_srdy && !w_s_clr) begin
                r_sovr <= 1'b1;
            end else if (w_s_ovr_clr) begin
                r_sovr <= 1'b0;
            end
            if (w_s_set) begin
                r_srdy <= 1'b1;
            end else if (w_s_clr) begin
                r_srdy <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = 32'h0;
        if (w_sel_kdata) begin
            w_rd_mux = {28'h0, r_kdata};
        end else if (w_sel_kctrl) begin
            w_rd_mux = {29'h0, r_kovr, 1'b0, r_krdy};
        end else if (w_sel_sdata) begin
            w_rd_mux = {22'h0, r_sdata};
        end else if (w_sel_sctrl) begin
            w_rd_mux = {29'h0, r_sovr, 1'b0, r_srdy};
        end else if (w_sel_ledr) begin
            w_rd_mux = {22'h0, r_ledr};
        end else if (w_sel_hex) begin
            w_rd_mux = {16'h0, r_hex};
        end
    end

    // Read samples pre-edge register values, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ledr     <= '0;
            r_hex      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= w_rd_mux;
            end
            if (bus.wr_en && w_sel_ledr) begin
                r_ledr <= bus.wr_data[9:0];
            end
            if (bus.wr_en && w_sel_hex) begin
                r_hex <= bus.wr_data[15:0];
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign ledr_out     = r_ledr;
    assign hex_out      = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_board_io_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_io_bus_slave
// Purpose  : Directed and randomized checks of board_io_bus_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_io_bus_slave;

    localparam logic [31:0] A_KDATA = 32'hF000_0000;
    localparam logic [31:0] A_KCTRL = 32'hF000_0004;
    localparam logic [31:0] A_SDATA = 32'hF000_0010;
    localparam logic [31:0] A_SCTRL = 32'hF000_0014;
    localparam logic [31:0] A_LEDR  = 32'hF000_0020;
    localparam logic [31:0] A_HEX   = 32'hF000_0030;
    localparam logic [31:0] A_UNMAP = 32'hF000_0040;
    localparam int          D       = 10;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  key_raw = 4'hF;
    logic [9:0]  sw_raw  = 10'h0;
    logic [9:0]  ledr_out;
    logic [15:0] hex_out;

    int n_chk  = 0;
    int n_fail = 0;

    board_io_bus_slave_if bus();

    board_io_bus_slave #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .key_raw  (key_raw),
        .sw_raw   (sw_raw),
        .ledr_out (ledr_out),
        .hex_out  (hex_out)
    );

    always #5 clk = ~clk;

    // Reference model: register contents after each edge, from pin histories.
    logic [3:0]  kh[$];
    logic [9:0]  sh[$];
    logic [3:0]  m_kdata, m_nk;
    logic [9:0]  m_sdata, m_ns, m_ledr;
    logic [15:0] m_hex;
    logic [31:0] m_rd_data;
    logic        m_rd_valid, m_kchg, m_schg, m_krdy, m_kovr, m_srdy, m_sovr;
    logic        mk_clr, ms_clr, mk_wclr, ms_wclr, m_stable;

    function automatic logic [31:0] m_lookup(input logic [31:0] a);
        case ({a[31:2], 2'b00})
            A_KDATA: return {28'h0, m_kdata};
            A_KCTRL: return {29'h0, m_kovr, 1'b0, m_krdy};
            A_SDATA: return {22'h0, m_sdata};
            A_SCTRL: return {29'h0, m_sovr, 1'b0, m_srdy};
            A_LEDR:  return {22'h0, m_ledr};
            A_HEX:   return {16'h0, m_hex};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_kdata = '0; m_sdata = '0; m_ledr = '0; m_hex = '0;
            m_rd_data = '0; m_rd_valid = 1'b0;
            m_kchg = 1'b0; m_schg = 1'b0;
            m_krdy = 1'b0; m_kovr = 1'b0; m_srdy = 1'b0; m_sovr = 1'b0;
            kh.delete(); sh.delete();
            for (int i = 0; i < D + 3; i++) begin
                kh.push_front(4'h0);
                sh.push_front(10'h0);
            end
        end else begin
            if (bus.rd_en) m_rd_data = m_lookup(bus.addr);
            m_rd_valid = bus.rd_en;
            mk_clr  = bus.rd_en && ({bus.addr[31:2], 2'b00} == A_KDATA);
            ms_clr  = bus.rd_en && ({bus.addr[31:2], 2'b00} == A_SDATA);
            mk_wclr = bus.wr_en && ({bus.addr[31:2], 2'b00} == A_KCTRL) && !bus.wr_data[2];
            ms_wclr = bus.wr_en && ({bus.addr[31:2], 2'b00} == A_SCTRL) && !bus.wr_data[2];
            if (m_kchg && m_krdy && !mk_clr) m_kovr = 1'b1; else if (mk_wclr) m_kovr = 1'b0;
            if (m_kchg) m_krdy = 1'b1; else if (mk_clr) m_krdy = 1'b0;
            if (m_schg && m_srdy && !ms_clr) m_sovr = 1'b1; else if (ms_wclr) m_sovr = 1'b0;
            if (m_schg) m_srdy = 1'b1; else if (ms_clr) m_srdy = 1'b0;
            if (bus.wr_en && ({bus.addr[31:2], 2'b00} == A_LEDR)) m_ledr = bus.wr_data[9:0];
            if (bus.wr_en && ({bus.addr[31:2], 2'b00} == A_HEX))  m_hex  = bus.wr_data[15:0];
            kh.push_front(~key_raw); void'(kh.pop_back());
            sh.push_front(sw_raw);   void'(sh.pop_back());
            // Keys: value seen at the pins two edges ago. Switches: only once
            // D+1 consecutive samples agree.
            m_nk = kh[2];
            m_stable = 1'b1;
            for (int i = 3; i <= D + 2; i++) if (sh[i] != sh[2]) m_stable = 1'b0;
            m_ns = m_stable ? sh[2] : m_sdata;
            m_kchg = (m_nk != m_kdata);
            m_schg = (m_ns != m_sdata);
            m_kdata = m_nk;
            m_sdata = m_ns;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a; bus.wr_data = d; bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        bus.addr = a; bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        d = bus.rd_data;
        v = bus.rd_valid;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        logic [31:0] regs [7];
        regs[0] = A_KDATA; regs[1] = A_KCTRL; regs[2] = A_SDATA; regs[3] = A_SCTRL;
        regs[4] = A_LEDR;  regs[5] = A_HEX;   regs[6] = A_UNMAP;
        @(negedge clk);
        reset_n = 1'b0; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        bus.addr = A_LEDR; bus.wr_data = 32'h3FF;
        @(negedge clk);
        n_chk++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid_in_reset: got %b want 0", bus.rd_valid); end
        n_chk++; if (ledr_out !== 10'h0) begin n_fail++; $display("FAIL reset_ledr_in_reset: got %h want 000", ledr_out); end
        @(negedge clk);
        n_chk++; if (hex_out !== 16'h0) begin n_fail++; $display("FAIL reset_hex: got %h want 0000", hex_out); end
        n_chk++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        reset_n = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_read(regs[i], d, v);
            n_chk++; if (d !== 32'h0 || v !== 1'b1) begin n_fail++; $display("FAIL reset_read[%0d]: got %h valid %b want 00000000 valid 1", i, d, v); end
        end
    endtask

    task automatic test_ledr_hex();
        logic [31:0] d;
        logic        v;
        do_write(A_LEDR, 32'h2A5);
        n_chk++; if (ledr_out !== 10'h2A5 || ledr_out !== m_ledr) begin n_fail++; $display("FAIL ledr_write: got %h want 2a5", ledr_out); end
        do_write(A_HEX, 32'hBEEF);
        n_chk++; if (hex_out !== 16'hBEEF) begin n_fail++; $display("FAIL hex_write: got %h want beef", hex_out); end
        do_read(A_HEX, d, v);
        n_chk++; if (d !== 32'h0000BEEF || v !== 1'b1) begin n_fail++; $display("FAIL hex_read: got %h valid %b want 0000beef valid 1", d, v); end
        @(negedge clk);
        n_chk++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL rd_hold: got %h valid %b want 0000beef valid 0", bus.rd_data, bus.rd_valid); end
        do_read(A_LEDR | 32'h2, d, v);
        n_chk++; if (d !== 32'h2A5) begin n_fail++; $display("FAIL low_addr_bits: got %h want 000002a5", d); end
    endtask

    task automatic test_key();
        logic [31:0] d;
        logic        v;
        @(negedge clk); key_raw = 4'b1110;
        idle(5);
        do_read(A_KCTRL, d, v);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL key_ready: got %h want 1", d); end
        do_read(A_KDATA, d, v);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL key_data: got %h want 1", d); end
        do_read(A_KCTRL, d, v);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL key_ready_clear: got %h want 0", d); end
        @(negedge clk); key_raw = 4'hF;
        idle(5);
        @(negedge clk); key_raw = 4'b1110;
        idle(5);
        do_read(A_KCTRL, d, v);
        n_chk++; if (d !== 32'h5) begin n_fail++; $display("FAIL key_overrun: got %h want 5", d); end
        do_write(A_KCTRL, 32'h5);
        do_read(A_KCTRL, d, v);
        n_chk++; if (d !== 32'h5) begin n_fail++; $display("FAIL kctrl_w1_keep: got %h want 5", d); end
        do_write(A_KCTRL, 32'h0);
        do_read(A_KCTRL, d, v);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL kctrl_w0_clear: got %h want 1", d); end
        @(negedge clk); key_raw = 4'hF;
        idle(5);
        do_read(A_KDATA, d, v);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL key_release: got %h want 0", d); end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        logic        v;
        int          first;
        @(negedge clk); sw_raw = 10'h001;
        idle(4);
        @(negedge clk); sw_raw = 10'h000;
        idle(15);
        do_read(A_SDATA, d, v);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_sdata: got %h want 0", d); end
        do_read(A_SCTRL, d, v);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_sctrl: got %h want 0", d); end
        // Read SDATA every cycle from the pin edge; the read issued on the
        // 14th edge is the first to see the value latched on edge 13.
        first = -1;
        @(negedge clk); sw_raw = 10'h001; bus.addr = A_SDATA; bus.rd_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.rd_data[0] && first < 0) first = i;
        end
        bus.rd_en = 1'b0;
        n_chk++; if (first != 13) begin n_fail++; $display("FAIL debounce_latency: got read %0d want read 13", first); end
        do_read(A_SCTRL, d, v);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL set_beats_clear: got %h want 1", d); end
        do_read(A_SDATA, d, v);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL sdata_value: got %h want 1", d); end
        do_read(A_SCTRL, d, v);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL sctrl_after_read: got %h want 0", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic        v;
        do_write(A_UNMAP, 32'hFFFF);
        do_write(A_KDATA, 32'hFFFF);
        do_write(A_SDATA, 32'hFFFF);
        n_chk++; if (ledr_out !== 10'h2A5 || hex_out !== 16'hBEEF) begin n_fail++; $display("FAIL ignored_write: got ledr %h hex %h want 2a5 beef", ledr_out, hex_out); end
        do_read(A_UNMAP, d, v);
        n_chk++; if (d !== 32'h0 || v !== 1'b1) begin n_fail++; $display("FAIL unmapped_read: got %h valid %b want 0 valid 1", d, v); end
        do_read(A_KDATA, d, v);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL kdata_ro: got %h want 0", d); end
        do_read(A_SDATA, d, v);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL sdata_ro: got %h want 1", d); end
    endtask

    task automatic test_simul_rw();
        @(negedge clk);
        bus.addr = A_LEDR; bus.wr_data = 32'h155; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        n_chk++; if (bus.rd_data !== 32'h2A5 || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL rw_old_value: got %h valid %b want 2a5 valid 1", bus.rd_data, bus.rd_valid); end
        n_chk++; if (ledr_out !== 10'h155) begin n_fail++; $display("FAIL rw_commit: got %h want 155", ledr_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sa [4];
        logic [31:0] se [4];
        sa[0] = A_LEDR; sa[1] = A_HEX;     sa[2] = A_UNMAP; sa[3] = A_LEDR | 32'h1;
        se[0] = 32'h155; se[1] = 32'hBEEF; se[2] = 32'h0;   se[3] = 32'h155;
        @(negedge clk); bus.addr = sa[0]; bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++; if (bus.rd_data !== se[i] || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d]: got %h valid %b want %h valid 1", i, bus.rd_data, bus.rd_valid, se[i]); end
            if (i < 3) bus.addr = sa[i + 1]; else bus.rd_en = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [7];
        pool[0] = A_KDATA; pool[1] = A_KCTRL; pool[2] = A_SDATA; pool[3] = A_SCTRL;
        pool[4] = A_LEDR;  pool[5] = A_HEX;   pool[6] = A_UNMAP;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_chk++; if (bus.rd_valid !== m_rd_valid || bus.rd_data !== m_rd_data) begin n_fail++; $display("FAIL rand_read c=%0d: got %h valid %b want %h valid %b", c, bus.rd_data, bus.rd_valid, m_rd_data, m_rd_valid); end
            n_chk++; if (ledr_out !== m_ledr || hex_out !== m_hex) begin n_fail++; $display("FAIL rand_outputs c=%0d: got ledr %h hex %h want %h %h", c, ledr_out, hex_out, m_ledr, m_hex); end
            reset_n     = ($urandom_range(0, 299) != 0);
            bus.rd_en   = ($urandom_range(0, 1) == 1);
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.addr    = pool[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
            bus.wr_data = $urandom;
            if ($urandom_range(0, 5) == 0)  key_raw = 4'($urandom);
            if ($urandom_range(0, 24) == 0) sw_raw  = 10'($urandom);
        end
        @(negedge clk);
        reset_n = 1'b1; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    endtask

    initial begin
        bus.addr = '0; bus.wr_data = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        test_reset();
        test_ledr_hex();
        test_key();
        test_debounce();
        test_unmapped();
        test_simul_rw();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
